// File: rtl/stopwatch_cmd_sched.sv
// stopwatch_cmd_sched: queues button/UART run-stop and clear requests and replays them as spaced 1-clk pulses.
// Ports: clk, rst_n (async active-low); btn_runstop/btn_clear button pulses; rx_data/rx_valid UART bytes;
// o_runstop/o_clear pulses to the control FSM; fifo_full; drop_cnt saturating drop count.
// Optional macro STOPWATCH_CMD_ECHO_EN adds tx_data/tx_valid/tx_ready echo of every issued command.
module stopwatch_cmd_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP = 2,
  parameter logic [7:0] CH_RUN = 8'h72,
  parameter logic [7:0] CH_CLR = 8'h63
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_runstop,
  input  logic       btn_clear,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
`ifdef STOPWATCH_CMD_ECHO_EN
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
`endif
  output logic       o_runstop,
  output logic       o_clear,
  output logic       fifo_full,
  output logic [7:0] drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] GAP_END = 8'((GAP > 0) ? GAP - 1 : 0);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nx;
  logic mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic [7:0] gap_cnt;
  logic uart_run, uart_clr, run_req, clr_req, full_blk, pop, push, flush, drop, stall;
  assign uart_run = rx_valid && ((rx_data | 8'h20) == CH_RUN);
  assign uart_clr = rx_valid && ((rx_data | 8'h20) == CH_CLR);
  assign run_req  = btn_runstop | uart_run;
  assign clr_req  = btn_clear | uart_clr;
  assign fifo_full = cnt == (AW+1)'(FIFO_DEPTH);
`ifdef STOPWATCH_CMD_ECHO_EN
  assign stall = tx_valid;
`else
  assign stall = 1'b0;
`endif
  assign pop = (state == IDLE) && (cnt != '0) && !stall;
  // a simultaneous pop frees a slot, so only a full FIFO without a pop blocks the write
  assign full_blk = fifo_full && !pop;
  assign flush = clr_req && full_blk;
  assign push  = clr_req || (run_req && !full_blk);
  // clear drops any same-cycle runstop; two runstop sources collapse to one entry
  assign drop  = clr_req ? run_req : (run_req && ((btn_runstop && uart_run) || full_blk));
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = pop ? ISSUE : IDLE;
    else if (state == ISSUE) state_nx = (GAP > 0) ? WAIT : IDLE;
    else if (state == WAIT) state_nx = (gap_cnt == GAP_END) ? IDLE : WAIT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gap_cnt <= '0;
      o_runstop <= 1'b0;
      o_clear <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_nx;
      gap_cnt <= (state == WAIT) ? gap_cnt + 8'd1 : 8'd0;
      o_runstop <= pop && !mem[rd_ptr];
      o_clear <= pop && mem[rd_ptr];
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
  // entry encoding: 1 = CLR, 0 = RUN
  always_ff @(posedge clk) begin
    if (flush) mem[0] <= 1'b1;
    else if (push) mem[wr_ptr] <= clr_req;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= AW'(1);
      cnt <= (AW+1)'(1);
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
`ifdef STOPWATCH_CMD_ECHO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data <= '0;
    end else if (pop) begin
      tx_valid <= 1'b1;
      tx_data <= mem[rd_ptr] ? 8'h43 : 8'h52;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_stopwatch_cmd_sched.sv
// tb_stopwatch_cmd_sched: directed and random stimulus checked against a queue-based reference model.
module tb_stopwatch_cmd_sched;
  localparam int DEPTH = 4;
  localparam int GAP = 2;
  logic clk = 0, rst_n = 1, btn_runstop = 0, btn_clear = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic o_runstop, o_clear, fifo_full;
  logic [7:0] drop_cnt;
  bit tr = 1;
`ifdef STOPWATCH_CMD_ECHO_EN
  logic [7:0] tx_data;
  logic tx_valid, tx_ready;
  assign tx_ready = tr;
`endif
  stopwatch_cmd_sched #(.FIFO_DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .btn_runstop(btn_runstop), .btn_clear(btn_clear),
    .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef STOPWATCH_CMD_ECHO_EN
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
`endif
    .o_runstop(o_runstop), .o_clear(o_clear), .fifo_full(fifo_full), .drop_cnt(drop_cnt));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  bit q[$];
  int cool = 0, drops = 0;
  bit e_run = 0, e_clr = 0, busy = 0;
  logic [7:0] e_tx = 0;
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("o_runstop", {7'b0, o_runstop}, {7'b0, e_run});
    chk("o_clear", {7'b0, o_clear}, {7'b0, e_clr});
    chk("fifo_full", {7'b0, fifo_full}, {7'b0, q.size() == DEPTH});
    chk("drop_cnt", drop_cnt, 8'(drops));
`ifdef STOPWATCH_CMD_ECHO_EN
    chk("tx_valid", {7'b0, tx_valid}, {7'b0, busy});
    if (busy) chk("tx_data", tx_data, e_tx);
`endif
  endtask
  task automatic model_reset();
    q.delete();
    cool = 0; drops = 0; e_run = 0; e_clr = 0; busy = 0;
  endtask
  // one clock edge of the scheduler, from the rules: queue of commands, issue cooldown, drop counting
  task automatic model_edge(bit br, bit bc, bit rv, logic [7:0] rd);
    bit ur, uc, run, clr, pop, fb, cmd;
    int sz;
    ur = rv && ((rd | 8'h20) == 8'h72);
    uc = rv && ((rd | 8'h20) == 8'h63);
    run = br || ur;
    clr = bc || uc;
    sz = q.size();
    pop = cool == 0 && sz > 0 && !busy;
    e_run = 0; e_clr = 0;
    if (pop) begin
      cmd = q.pop_front();
      e_run = !cmd; e_clr = cmd;
      e_tx = cmd ? 8'h43 : 8'h52;
      cool = GAP + 1;
    end else if (cool > 0) cool--;
`ifdef STOPWATCH_CMD_ECHO_EN
    busy = pop || (busy && !tr);
`endif
    fb = sz == DEPTH && !pop;
    if (clr) begin
      if (fb) q.delete();
      q.push_back(1'b1);
    end else if (run && !fb) q.push_back(1'b0);
    if (((clr && run) || (!clr && run && ((br && ur) || fb))) && drops < 255) drops++;
  endtask
  task automatic cyc(bit br, bit bc, bit rv, logic [7:0] rd);
    btn_runstop = br; btn_clear = bc; rx_valid = rv; rx_data = rd;
    @(posedge clk);
    model_edge(br, bc, rv, rd);
    @(negedge clk);
    check_all();
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00);
  endtask
  task automatic do_reset();
    rst_n = 0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  logic [7:0] pool [6] = '{8'h72, 8'h52, 8'h63, 8'h43, 8'h41, 8'h00};
  initial begin
    int pulses, k;
    #1 rst_n = 0;
    #2 check_all();
    @(negedge clk);
    rst_n = 1;
    // single command: 'R' over UART
    pulses = 0;
    cyc(0, 0, 1, 8'h52);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 8'h00);
      pulses += o_runstop;
    end
    chk("single_pulses", 8'(pulses), 8'd1);
    chk("single_drop", drop_cnt, 8'd0);
    // burst of runstop presses
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 8'h00);
    idle(30);
    // clear priority over a same-cycle runstop
    cyc(1, 0, 1, 8'h63);
    idle(10);
    // invalid bytes are neither queued nor counted
    k = drops;
    cyc(0, 0, 1, 8'h41);
    cyc(0, 0, 1, 8'h00);
    idle(5);
    chk("invalid_nocount", drop_cnt, 8'(k));
    // fill to full, then clear flushes
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 8'h00);
    chk("flush_pre_full", {7'b0, fifo_full}, 8'd1);
    cyc(0, 1, 0, 8'h00);
    idle(20);
    // saturation with double-source and full drops
    for (int i = 0; i < 300; i++) cyc(1, 0, 1, 8'h72);
    chk("sat", drop_cnt, 8'd255);
    idle(30);
    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
`ifdef STOPWATCH_CMD_ECHO_EN
      tr = $urandom_range(0, 1) == 1;
`endif
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
          ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 5)]);
    end
    tr = 1;
    idle(30);
    // reset mid-queue with a pulse high
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h00);
    k = 0;
    while (!e_run && k < 20) begin
      cyc(0, 0, 0, 8'h00);
      k++;
    end
    chk("pending_pulse", {7'b0, o_runstop}, 8'd1);
    do_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 8'h00);
      pulses += o_runstop + o_clear;
    end
    chk("post_reset_pulses", 8'(pulses), 8'd0);
`ifdef STOPWATCH_CMD_ECHO_EN
    // echo stall: second command waits for tx_ready
    tr = 0;
    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    idle(12);
    chk("echo_stall_valid", {7'b0, tx_valid}, 8'd1);
    tr = 1;
    idle(12);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
